// File: rtl/serialtopar_pkg.sv
// Shared definitions for the serialtopar_sync deserialiser: FSM state
// encoding and the default comma/idle symbol.
package serialtopar_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

endpackage

// File: rtl/serialtopar_sync_fsm.sv
// Alignment FSM for serialtopar_sync: word-phase counter, comma counter and
// lock state. Build option SERIALTOPAR_SYNC_REALIGN_EN adds a misaligned-comma
// counter that drops lock after MISALIGN_LIMIT off-phase commas.
module serialtopar_sync_fsm
    import serialtopar_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int LOCK_COUNT     = 4,
    parameter int MISALIGN_LIMIT = 2
) (
    input  logic   clk,
    input  logic   reset_L,
    input  logic   comma_match,
    output state_t state,
    output logic   emit,
    output logic   locked_nxt
);

    localparam int CW = $clog2(WIDTH);

    state_t          state_q, state_nxt;
    logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
    logic [3:0]      comma_cnt, comma_cnt_nxt;
    logic            emit_q, emit_nxt;
    logic            boundary;

`ifdef SERIALTOPAR_SYNC_REALIGN_EN
    localparam int MW = (MISALIGN_LIMIT < 2) ? 1 : $clog2(MISALIGN_LIMIT + 1);
    logic [MW-1:0]   mis_cnt, mis_cnt_nxt;
`else
    // The limit only matters when realignment is built in.
    if (MISALIGN_LIMIT < 1) begin : g_no_realign
    end
`endif

    // Last bit of a word arrives when the phase counter sits at WIDTH-1.
    assign boundary = (bit_cnt == CW'(WIDTH - 1));

    // State register: lock state, word phase, comma count, emit pulse.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= SEARCH;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            emit_q    <= 1'b0;
`ifdef SERIALTOPAR_SYNC_REALIGN_EN
            mis_cnt   <= '0;
`endif
        end else begin
            state_q   <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            comma_cnt <= comma_cnt_nxt;
            emit_q    <= emit_nxt;
`ifdef SERIALTOPAR_SYNC_REALIGN_EN
            mis_cnt   <= mis_cnt_nxt;
`endif
        end
    end

    // Next-state logic: bit-wise comma hunt, boundary-qualified lock count.
    always_comb begin
        state_nxt     = state_q;
        comma_cnt_nxt = comma_cnt;
        bit_cnt_nxt   = boundary ? '0 : bit_cnt + CW'(1);
        emit_nxt      = 1'b0;
`ifdef SERIALTOPAR_SYNC_REALIGN_EN
        mis_cnt_nxt   = mis_cnt;
`endif
        case (state_q)
            SEARCH: begin
                if (comma_match) begin
                    bit_cnt_nxt   = '0;
                    comma_cnt_nxt = 4'd1;
                    state_nxt     = (LOCK_COUNT == 1) ? LOCKED : LOCKING;
                end
            end
            LOCKING: begin
                if (boundary) begin
                    if (comma_match) begin
                        comma_cnt_nxt = comma_cnt + 4'd1;
                        if (comma_cnt_nxt == 4'(LOCK_COUNT))
                            state_nxt = LOCKED;
                    end else begin
                        comma_cnt_nxt = '0;
                        state_nxt     = SEARCH;
                    end
                end
            end
            LOCKED: begin
                emit_nxt = boundary;
`ifdef SERIALTOPAR_SYNC_REALIGN_EN
                if (comma_match) begin
                    if (boundary) begin
                        mis_cnt_nxt = '0;
                    end else if (mis_cnt + MW'(1) == MW'(MISALIGN_LIMIT)) begin
                        mis_cnt_nxt   = '0;
                        comma_cnt_nxt = '0;
                        emit_nxt      = 1'b0;
                        state_nxt     = SEARCH;
                    end else begin
                        mis_cnt_nxt = mis_cnt + MW'(1);
                    end
                end
`endif
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // Outputs: registered state and emit pulse, plus look-ahead lock flag.
    always_comb begin
        state      = state_q;
        emit       = emit_q;
        locked_nxt = (state_nxt == LOCKED);
    end

endmodule

// File: rtl/serialtopar_sync.sv
// serialtopar_sync: parametrised serial-to-parallel deserialiser with comma
// alignment. Holds the shift register, comma comparator and output registers;
// alignment lives in serialtopar_sync_fsm. Optional build macro:
// SERIALTOPAR_SYNC_REALIGN_EN (drop lock on repeated misaligned commas).
module serialtopar_sync
    import serialtopar_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] COMMA          = WIDTH'(COMMA_DEFAULT),
    parameter int               LOCK_COUNT     = 4,
    parameter int               MISALIGN_LIMIT = 2
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             word_strobe,
    output logic             locked
);

    logic [WIDTH-1:0] sr, sr_nxt;
    logic             comma_match;
    logic             emit;
    logic             locked_nxt;
    state_t           state;

    assign sr_nxt      = {sr[WIDTH-2:0], data_in};
    assign comma_match = (sr_nxt == COMMA);
    assign locked      = (state == LOCKED);

    serialtopar_sync_fsm #(
        .WIDTH          (WIDTH),
        .LOCK_COUNT     (LOCK_COUNT),
        .MISALIGN_LIMIT (MISALIGN_LIMIT)
    ) u_fsm (
        .clk         (clk),
        .reset_L     (reset_L),
        .comma_match (comma_match),
        .state       (state),
        .emit        (emit),
        .locked_nxt  (locked_nxt)
    );

    // Serial shift, MSB first, in every state.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) sr <= '0;
        else          sr <= sr_nxt;
    end

    // Word output one cycle after the boundary; sr then holds the whole word.
    // Losing lock suppresses a pending word and clears valid.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out    <= '0;
            valid_out   <= 1'b0;
            word_strobe <= 1'b0;
        end else if (emit && locked_nxt) begin
            data_out    <= sr;
            valid_out   <= (sr != COMMA);
            word_strobe <= 1'b1;
        end else begin
            word_strobe <= 1'b0;
            if (!locked_nxt) valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serialtopar_sync.sv
// Bench for serialtopar_sync (WIDTH=8, COMMA=BC, LOCK_COUNT=4): directed
// byte streams, expected words queued at issue, monitor pops on word_strobe.
module tb_serialtopar_sync;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       word_strobe;
    logic       locked;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_strobe = -1;

    serialtopar_sync dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .word_strobe (word_strobe),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    // Byte sent while unlocked (or partial-word filler): no word expected.
    task automatic send_raw(input logic [7:0] v);
        send_bits(v, 8);
    endtask

    // Byte sent while locked: expected word and valid queued for the monitor.
    task automatic send_data(input logic [7:0] v, input logic ev);
        exp_q.push_back('{d: v, v: ev});
        send_bits(v, 8);
    endtask

    task automatic reset_pulse(input bool_chk);
        reset_L = 1'b0;
        #1;
        if (bool_chk) begin
            chk("rst_async_data",   32'(data_out), 32'h0);
            chk("rst_async_valid",  32'(valid_out), 32'h0);
            chk("rst_async_strobe", 32'(word_strobe), 32'h0);
            chk("rst_async_locked", 32'(locked), 32'h0);
        end
        @(posedge clk);
        #1;
        reset_L = 1'b1;
    endtask

    // Monitor: compares every presented word and checks strobe spacing.
    always @(negedge clk) begin
        cyc++;
        if (!locked) last_strobe = -1;
        if (word_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got data %0h valid %0b expected no word", data_out, valid_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word_data",  32'(data_out),  32'(e.d));
                chk("word_valid", 32'(valid_out), 32'(e.v));
            end
            if (last_strobe >= 0) chk("strobe_period", 32'(cyc - last_strobe), 32'd8);
            last_strobe = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data",   32'(data_out), 32'h0);
        chk("reset_valid",  32'(valid_out), 32'h0);
        chk("reset_strobe", 32'(word_strobe), 32'h0);
        chk("reset_locked", 32'(locked), 32'h0);
        reset_L = 1'b1;

        // Lock and data path
        repeat (3) send_raw(8'hBC);
        chk("lock_after_3", 32'(locked), 32'h0);
        send_raw(8'hBC);
        chk("lock_after_4", 32'(locked), 32'h1);
        chk("lock_valid0",  32'(valid_out), 32'h0);
        send_data(8'hFF, 1'b1);
        send_data(8'hEE, 1'b1);
        send_data(8'hDD, 1'b1);

        // Idle handling
        send_data(8'hBC, 1'b0);
        send_data(8'hAA, 1'b1);

        // Reset mid-word while locked, then relock
        send_bits(8'h05, 3);
        reset_pulse(1'b1);
        repeat (3) send_raw(8'hBC);
        chk("relock_after_3", 32'(locked), 32'h0);
        send_raw(8'hBC);
        chk("relock_after_4", 32'(locked), 32'h1);
        send_data(8'h5A, 1'b1);
        send_bits(8'h00, 2);
        reset_pulse(1'b0);

        // Failed lock
        repeat (3) send_raw(8'hBC);
        send_raw(8'h55);
        chk("fail_lock_55", 32'(locked), 32'h0);
        repeat (3) send_raw(8'hBC);
        chk("fail_lock_3", 32'(locked), 32'h0);
        send_raw(8'hBC);
        chk("fail_lock_relock", 32'(locked), 32'h1);
        send_data(8'h12, 1'b1);
        send_bits(8'h00, 2);
        reset_pulse(1'b0);

        // Arbitrary bit alignment
        send_bits(8'h05, 3);
        repeat (4) send_raw(8'hBC);
        chk("align_locked", 32'(locked), 32'h1);
        send_data(8'h3C, 1'b1);

`ifdef SERIALTOPAR_SYNC_REALIGN_EN
        // Realignment: 3-bit slip, two off-phase commas drop lock
        send_data(8'h00, 1'b1);
        exp_q.push_back('{d: 8'h17, v: 1'b1});
        exp_q.push_back('{d: 8'h97, v: 1'b1});
        send_bits(8'h00, 3);
        send_raw(8'hBC);
        chk("realign_hold", 32'(locked), 32'h1);
        send_raw(8'hBC);
        chk("realign_drop",  32'(locked), 32'h0);
        chk("realign_valid", 32'(valid_out), 32'h0);
        repeat (3) send_raw(8'hBC);
        chk("realign_relock_3", 32'(locked), 32'h0);
        send_raw(8'hBC);
        chk("realign_relock", 32'(locked), 32'h1);
        send_data(8'hC3, 1'b1);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
